decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
Pipeline stage directly downstream of instruction fetch. It accepts one fetched RV32I instruction and its PC per valid/ready handshake. It extracts register indices, builds the sign-extended immediate, and produces control flags. It holds the result in an output register toward execute, and on a writeback redirect it discards the wrong-path instruction.

Parameters:
XLEN, 32, datapath width; must equal rvga_word width.
REG_IDX_W, 5, register index width.

Ports:
clk  input  1  clock; all state updates on posedge.
rst  input  1  asynchronous, active-low reset.
ifetch_decode_valid  input  1  instruction/pc inputs valid this cycle.
ifetch_decode_pc  input  XLEN  PC of the offered instruction.
ifetch_decode_instruction  input  XLEN  raw instruction word.
decode_ifetch_ready  output  1  decode can accept this cycle.
decode_execute_valid  output  1  decoded bundle valid.
execute_decode_ready  input  1  execute consumes the bundle this cycle.
decode_execute_pc  output  XLEN  registered PC.
decode_execute_rs1  output  REG_IDX_W  instr[19:15].
decode_execute_rs2  output  REG_IDX_W  instr[24:20].
decode_execute_rd  output  REG_IDX_W  instr[11:7]; forced 0 when reg_write=0.
decode_execute_imm  output  XLEN  sign-extended immediate.
decode_execute_funct3  output  3  instr[14:12].
decode_execute_alu_op  output  4  {alt, funct3} for OP/OP-IMM; 4'b0000 (ADD) otherwise.
decode_execute_ctrl  output  9  {illegal, auipc, lui, jalr, jal, branch, mem_write, mem_read, reg_write}.
writeback_decode_flush  input  1  redirect: kill held and incoming instruction.

Behaviour:
- Reset (rst low, asynchronous): decode_execute_valid=0 and all registered outputs=0. Registers stay in reset until rst rises. A reset that arrives mid-handshake drops the bundle with no partial output.
- decode_ifetch_ready = !decode_execute_valid || execute_decode_ready. This is combinational with no dependency on ifetch_decode_valid.
- Load condition: ifetch_decode_valid && decode_ifetch_ready && !writeback_decode_flush. All outputs are registered on load; latency is 1 cycle from accept to decode_execute_valid.
- Valid update:
  - Load → valid=1.
  - Else execute_decode_ready → valid=0.
  - Else valid holds.
- Flush: valid=0 next cycle regardless of other inputs. If the input handshake fires in the same cycle, that instruction is consumed and discarded.
- Stall (valid=1, ready=0): all outputs hold bit-stable.
- Back-to-back throughput is 1 per cycle when execute_decode_ready stays high.
- Immediate formats:
  - I: OP-IMM, LOAD, JALR.
  - S: STORE.
  - B: BRANCH, bit0=0.
  - U: LUI, AUIPC, low 12 bits=0.
  - J: JAL, bit0=0.
  - R-type and illegal: imm=0.
  - All formats sign-extend from instr[31].
- alt bit:
  - OP: instr[30].
  - OP-IMM: instr[30] only when funct3=101; otherwise 0.
- Illegal conditions, any of:
  - instr[1:0] != 2'b11.
  - Opcode outside {LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP}.
  - BRANCH funct3 in {010, 011}.
  - LOAD funct3 in {011, 110, 111}.
  - STORE funct3 > 010.
  - JALR funct3 != 000.
  - OP funct7 not in {0x00, 0x20}, or funct7=0x20 with funct3 not in {000, 101}.
  - OP-IMM shift (funct3 001/101) with an illegal funct7.
- When illegal: all other ctrl bits=0, rd=0, and valid is still asserted so execute can trap.
- reg_write=1 for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP.
- mem_read=1 for LOAD; mem_write=1 for STORE; branch=1 for BRANCH.
- No register file or hazard detection in this block.

Test Plan:
- Reset with rst low while ifetch_decode_valid=1 → decode_execute_valid=0, decode_ifetch_ready=1; after rst rises, 0x00500093 at pc 0x80000000 → next cycle valid=1, rd=1, rs1=0, imm=5, alu_op=0000, ctrl=9'h001.
- Decode all immediate formats, one per cycle, execute ready held high:
  - 0x0020A423 (sw) → imm=8, rs1=1, rs2=2, rd=0, ctrl=9'h004.
  - 0xFE000EE3 (beq) → imm=0xFFFFFFFC, ctrl=9'h008.
  - 0x123452B7 (lui) → imm=0x12345000, rd=5.
  - 0x008000EF (jal) → imm=8, rd=1.
- Back-pressure: execute_decode_ready=0 for 3 cycles with a new input offered → decode_ifetch_ready=0 and outputs unchanged. Release → held bundle is consumed, then the new one appears the next cycle; no loss or duplication.
- Flush:
  - writeback_decode_flush=1 while valid=1 and a new input is offered → next cycle valid=0; the new instruction never appears.
  - Flush with no instruction held → no effect besides valid=0.
- Illegal: 0x00000000, 0x40001033 (funct7=0x20, funct3=001), 0x0000A003 (LOAD, funct3=010, legal; compare against) → first two give ctrl=9'h100, rd=0, valid=1; the third gives ctrl=9'h003.
- Asynchronous reset asserted between clock edges while valid=1 and stalled → valid drops immediately, before the next edge.

Source files
------------

// File: rtl/decode_stage.sv
// RV32I decode stage: sits between fetch and execute, turns one raw
// instruction per handshake into register indices, a sign-extended immediate
// and control flags, and holds the result in an output register until execute
// takes it. A writeback redirect kills both the held and the incoming bundle.
module decode_stage #(
    parameter int XLEN      = 32,
    parameter int REG_IDX_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ifetch_decode_valid,
    input  logic [XLEN-1:0]      ifetch_decode_pc,
    input  logic [XLEN-1:0]      ifetch_decode_instruction,
    output logic                 decode_ifetch_ready,
    output logic                 decode_execute_valid,
    input  logic                 execute_decode_ready,
    output logic [XLEN-1:0]      decode_execute_pc,
    output logic [REG_IDX_W-1:0] decode_execute_rs1,
    output logic [REG_IDX_W-1:0] decode_execute_rs2,
    output logic [REG_IDX_W-1:0] decode_execute_rd,
    output logic [XLEN-1:0]      decode_execute_imm,
    output logic [2:0]           decode_execute_funct3,
    output logic [3:0]           decode_execute_alu_op,
    output logic [8:0]           decode_execute_ctrl,
    input  logic                 writeback_decode_flush
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // Field extraction from the offered instruction
    logic [XLEN-1:0] instr_s;
    logic [6:0]      opcode_s;
    logic [2:0]      funct3_s;
    logic [6:0]      funct7_s;

    // Immediate candidates, one per encoding format
    logic [XLEN-1:0] imm_i_s;
    logic [XLEN-1:0] imm_s_s;
    logic [XLEN-1:0] imm_b_s;
    logic [XLEN-1:0] imm_u_s;
    logic [XLEN-1:0] imm_j_s;

    // Raw decode results before illegal-instruction suppression
    logic            illegal_s;
    logic            reg_write_s;
    logic            mem_read_s;
    logic            mem_write_s;
    logic            branch_s;
    logic            jal_s;
    logic            jalr_s;
    logic            lui_s;
    logic            auipc_s;
    logic            alu_sel_s;
    logic            alt_s;
    logic [XLEN-1:0] imm_raw_s;

    // Final bundle presented to the output register
    logic [8:0]           ctrl_s;
    logic [REG_IDX_W-1:0] rd_s;
    logic [XLEN-1:0]      imm_s;
    logic [3:0]           alu_op_s;

    // Handshake
    logic ready_s;
    logic load_s;

    // Output register state
    logic                 valid_q,  valid_d;
    logic [XLEN-1:0]      pc_q,     pc_d;
    logic [REG_IDX_W-1:0] rs1_q,    rs1_d;
    logic [REG_IDX_W-1:0] rs2_q,    rs2_d;
    logic [REG_IDX_W-1:0] rd_q,     rd_d;
    logic [XLEN-1:0]      imm_q,    imm_d;
    logic [2:0]           funct3_q, funct3_d;
    logic [3:0]           alu_op_q, alu_op_d;
    logic [8:0]           ctrl_q,   ctrl_d;

    assign instr_s  = ifetch_decode_instruction;
    assign opcode_s = instr_s[6:0];
    assign funct3_s = instr_s[14:12];
    assign funct7_s = instr_s[31:25];

    // All formats sign-extend from bit 31; B and J always have bit0 clear.
    assign imm_i_s = {{(XLEN-12){instr_s[31]}}, instr_s[31:20]};
    assign imm_s_s = {{(XLEN-12){instr_s[31]}}, instr_s[31:25], instr_s[11:7]};
    assign imm_b_s = {{(XLEN-13){instr_s[31]}}, instr_s[31], instr_s[7],
                      instr_s[30:25], instr_s[11:8], 1'b0};
    assign imm_u_s = {{(XLEN-32){instr_s[31]}}, instr_s[31:12], 12'h000};
    assign imm_j_s = {{(XLEN-21){instr_s[31]}}, instr_s[31], instr_s[19:12],
                      instr_s[20], instr_s[30:21], 1'b0};

    // Classify the opcode, pick its immediate format and flag illegal encodings.
    always_comb begin
        illegal_s   = 1'b0;
        reg_write_s = 1'b0;
        mem_read_s  = 1'b0;
        mem_write_s = 1'b0;
        branch_s    = 1'b0;
        jal_s       = 1'b0;
        jalr_s      = 1'b0;
        lui_s       = 1'b0;
        auipc_s     = 1'b0;
        alu_sel_s   = 1'b0;
        alt_s       = 1'b0;
        imm_raw_s   = '0;
        if (instr_s[1:0] != 2'b11) begin
            illegal_s = 1'b1;
        end else begin
            case (opcode_s)
                OPC_LUI: begin
                    reg_write_s = 1'b1;
                    lui_s       = 1'b1;
                    imm_raw_s   = imm_u_s;
                end
                OPC_AUIPC: begin
                    reg_write_s = 1'b1;
                    auipc_s     = 1'b1;
                    imm_raw_s   = imm_u_s;
                end
                OPC_JAL: begin
                    reg_write_s = 1'b1;
                    jal_s       = 1'b1;
                    imm_raw_s   = imm_j_s;
                end
                OPC_JALR: begin
                    reg_write_s = 1'b1;
                    jalr_s      = 1'b1;
                    imm_raw_s   = imm_i_s;
                    illegal_s   = (funct3_s != 3'b000);
                end
                OPC_BRANCH: begin
                    branch_s  = 1'b1;
                    imm_raw_s = imm_b_s;
                    illegal_s = (funct3_s == 3'b010) || (funct3_s == 3'b011);
                end
                OPC_LOAD: begin
                    reg_write_s = 1'b1;
                    mem_read_s  = 1'b1;
                    imm_raw_s   = imm_i_s;
                    illegal_s   = (funct3_s == 3'b011) || (funct3_s == 3'b110) ||
                                  (funct3_s == 3'b111);
                end
                OPC_STORE: begin
                    mem_write_s = 1'b1;
                    imm_raw_s   = imm_s_s;
                    illegal_s   = (funct3_s > 3'b010);
                end
                OPC_OP_IMM: begin
                    reg_write_s = 1'b1;
                    alu_sel_s   = 1'b1;
                    imm_raw_s   = imm_i_s;
                    case (funct3_s)
                        3'b001: begin
                            illegal_s = (funct7_s != 7'h00);
                        end
                        3'b101: begin
                            illegal_s = (funct7_s != 7'h00) && (funct7_s != 7'h20);
                            alt_s     = instr_s[30];
                        end
                        default: begin
                            illegal_s = 1'b0;
                        end
                    endcase
                end
                OPC_OP: begin
                    reg_write_s = 1'b1;
                    alu_sel_s   = 1'b1;
                    alt_s       = instr_s[30];
                    if (funct7_s == 7'h00) begin
                        illegal_s = 1'b0;
                    end else if (funct7_s == 7'h20) begin
                        illegal_s = !((funct3_s == 3'b000) || (funct3_s == 3'b101));
                    end else begin
                        illegal_s = 1'b1;
                    end
                end
                default: begin
                    illegal_s = 1'b1;
                end
            endcase
        end
    end

    // An illegal instruction carries only the trap flag: no writes, no immediate, ADD op.
    always_comb begin
        if (illegal_s) begin
            ctrl_s   = 9'h100;
            rd_s     = '0;
            imm_s    = '0;
            alu_op_s = 4'b0000;
        end else begin
            ctrl_s   = {1'b0, auipc_s, lui_s, jalr_s, jal_s, branch_s,
                        mem_write_s, mem_read_s, reg_write_s};
            rd_s     = reg_write_s ? instr_s[11:7] : '0;
            imm_s    = imm_raw_s;
            alu_op_s = alu_sel_s ? {alt_s, funct3_s} : 4'b0000;
        end
    end

    // The slot accepts when empty or being drained; a redirect swallows the offer.
    always_comb begin
        ready_s = !valid_q || execute_decode_ready;
        load_s  = ifetch_decode_valid && ready_s && !writeback_decode_flush;
        if (writeback_decode_flush) begin
            valid_d = 1'b0;
        end else if (load_s) begin
            valid_d = 1'b1;
        end else if (execute_decode_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Bundle payload only changes on load, so a stalled bundle stays bit-stable.
    always_comb begin
        if (load_s) begin
            pc_d     = ifetch_decode_pc;
            rs1_d    = instr_s[19:15];
            rs2_d    = instr_s[24:20];
            rd_d     = rd_s;
            imm_d    = imm_s;
            funct3_d = funct3_s;
            alu_op_d = alu_op_s;
            ctrl_d   = ctrl_s;
        end else begin
            pc_d     = pc_q;
            rs1_d    = rs1_q;
            rs2_d    = rs2_q;
            rd_d     = rd_q;
            imm_d    = imm_q;
            funct3_d = funct3_q;
            alu_op_d = alu_op_q;
            ctrl_d   = ctrl_q;
        end
    end

    // Output register toward execute; asynchronous reset clears the whole bundle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q  <= 1'b0;
            pc_q     <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            rd_q     <= '0;
            imm_q    <= '0;
            funct3_q <= 3'b000;
            alu_op_q <= 4'b0000;
            ctrl_q   <= 9'h000;
        end else begin
            valid_q  <= valid_d;
            pc_q     <= pc_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            rd_q     <= rd_d;
            imm_q    <= imm_d;
            funct3_q <= funct3_d;
            alu_op_q <= alu_op_d;
            ctrl_q   <= ctrl_d;
        end
    end

    assign decode_ifetch_ready   = ready_s;
    assign decode_execute_valid  = valid_q;
    assign decode_execute_pc     = pc_q;
    assign decode_execute_rs1    = rs1_q;
    assign decode_execute_rs2    = rs2_q;
    assign decode_execute_rd     = rd_q;
    assign decode_execute_imm    = imm_q;
    assign decode_execute_funct3 = funct3_q;
    assign decode_execute_alu_op = alu_op_q;
    assign decode_execute_ctrl   = ctrl_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: a slot-level model of the output register plus a
// rule-based RV32I decoder, checked every falling edge, plus directed
// literal checks taken from hand decoding of the test vectors.
module tb_decode_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [2:0]  f3;
        logic [3:0]  alu;
        logic [8:0]  ctrl;
    } bundle_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifv;
    logic [31:0] pc_in;
    logic [31:0] instr_in;
    logic        ex_rdy;
    logic        flush;

    logic        dut_ready;
    logic        dut_valid;
    logic [31:0] dut_pc;
    logic [4:0]  dut_rs1;
    logic [4:0]  dut_rs2;
    logic [4:0]  dut_rd;
    logic [31:0] dut_imm;
    logic [2:0]  dut_f3;
    logic [3:0]  dut_alu;
    logic [8:0]  dut_ctrl;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32), .REG_IDX_W(5)) dut (
        .clk                       (clk),
        .rst                       (rst),
        .ifetch_decode_valid       (ifv),
        .ifetch_decode_pc          (pc_in),
        .ifetch_decode_instruction (instr_in),
        .decode_ifetch_ready       (dut_ready),
        .decode_execute_valid      (dut_valid),
        .execute_decode_ready      (ex_rdy),
        .decode_execute_pc         (dut_pc),
        .decode_execute_rs1        (dut_rs1),
        .decode_execute_rs2        (dut_rs2),
        .decode_execute_rd         (dut_rd),
        .decode_execute_imm        (dut_imm),
        .decode_execute_funct3     (dut_f3),
        .decode_execute_alu_op     (dut_alu),
        .decode_execute_ctrl       (dut_ctrl),
        .writeback_decode_flush    (flush)
    );

    // Reference decoder written from the ISA rules using signed arithmetic.
    function automatic bundle_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
        bundle_t     b;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] sx;
        logic        ill, rw, mr, mw, br, jl, jr, lu, au, alu_sel, alt;
        op = ins[6:0];
        f3 = ins[14:12];
        f7 = ins[31:25];
        sx = ins;
        ill = 1'b0; rw = 1'b0; mr = 1'b0; mw = 1'b0; br = 1'b0;
        jl = 1'b0; jr = 1'b0; lu = 1'b0; au = 1'b0; alu_sel = 1'b0; alt = 1'b0;
        b = '0;
        b.pc  = pc;
        b.rs1 = ins[19:15];
        b.rs2 = ins[24:20];
        b.f3  = f3;
        if (ins[1:0] != 2'b11) ill = 1'b1;
        else if (op == 7'h37) begin rw = 1'b1; lu = 1'b1; b.imm = ins & 32'hFFFF_F000; end
        else if (op == 7'h17) begin rw = 1'b1; au = 1'b1; b.imm = ins & 32'hFFFF_F000; end
        else if (op == 7'h6F) begin
            rw = 1'b1; jl = 1'b1;
            b.imm = 32'($signed(sx) >>> 31) << 20 | (32'(ins[19:12]) << 12)
                  | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
        end
        else if (op == 7'h67) begin
            rw = 1'b1; jr = 1'b1; ill = (f3 != 3'd0);
            b.imm = 32'($signed(sx) >>> 20);
        end
        else if (op == 7'h63) begin
            br = 1'b1; ill = (f3 == 3'd2) || (f3 == 3'd3);
            b.imm = 32'($signed(sx) >>> 31) << 12 | (32'(ins[7]) << 11)
                  | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
        end
        else if (op == 7'h03) begin
            rw = 1'b1; mr = 1'b1; ill = f3 inside {3'd3, 3'd6, 3'd7};
            b.imm = 32'($signed(sx) >>> 20);
        end
        else if (op == 7'h23) begin
            mw = 1'b1; ill = (f3 > 3'd2);
            b.imm = (32'($signed(sx) >>> 25) << 5) | 32'(ins[11:7]);
        end
        else if (op == 7'h13) begin
            rw = 1'b1; alu_sel = 1'b1;
            b.imm = 32'($signed(sx) >>> 20);
            if (f3 == 3'd1) ill = (f7 != 7'd0);
            if (f3 == 3'd5) begin ill = !(f7 == 7'd0 || f7 == 7'd32); alt = ins[30]; end
        end
        else if (op == 7'h33) begin
            rw = 1'b1; alu_sel = 1'b1; alt = ins[30];
            ill = !((f7 == 7'd0) || (f7 == 7'd32 && (f3 == 3'd0 || f3 == 3'd5)));
        end
        else ill = 1'b1;
        if (ill) begin
            b.ctrl = 9'h100;
            b.imm  = 32'd0;
            b.rd   = 5'd0;
            b.alu  = 4'd0;
        end else begin
            b.ctrl = {1'b0, au, lu, jr, jl, br, mw, mr, rw};
            b.rd   = rw ? ins[11:7] : 5'd0;
            b.alu  = alu_sel ? {alt, f3} : 4'd0;
        end
        return b;
    endfunction

    // Slot model: what execute should see after each edge.
    bit      m_valid;
    bundle_t m_b;
    bit      m_take;
    bit      m_give;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_valid = 1'b0;
            m_b     = '0;
        end else begin
            m_give = m_valid && ex_rdy;
            m_take = ifv && (!m_valid || ex_rdy) && !flush;
            if (m_take) m_b = ref_decode(instr_in, pc_in);
            m_valid = flush ? 1'b0 : (m_take || (m_valid && !m_give));
        end
    end

    // Compare DUT against the model on every falling edge out of reset.
    bundle_t act_b;
    bundle_t exp_b;
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            n_tests++;
            if (dut_ready !== (!m_valid || ex_rdy)) begin
                n_fail++;
                $display("FAIL model_ready: got %0b expected %0b", dut_ready, !m_valid || ex_rdy);
            end
            n_tests++;
            if (dut_valid !== m_valid) begin
                n_fail++;
                $display("FAIL model_valid: got %0b expected %0b", dut_valid, m_valid);
            end
            if (m_valid) begin
                act_b = {dut_pc, dut_rs1, dut_rs2, dut_rd, dut_imm, dut_f3, dut_alu, dut_ctrl};
                exp_b = m_b;
                if (exp_b.ctrl[8]) begin
                    act_b.alu = 4'd0;
                    exp_b.alu = 4'd0;
                end
                n_tests++;
                if (act_b !== exp_b) begin
                    n_fail++;
                    $display("FAIL model_bundle: got pc=%h rs1=%0d rs2=%0d rd=%0d imm=%h f3=%0d alu=%h ctrl=%h expected pc=%h rs1=%0d rs2=%0d rd=%0d imm=%h f3=%0d alu=%h ctrl=%h",
                             act_b.pc, act_b.rs1, act_b.rs2, act_b.rd, act_b.imm, act_b.f3, act_b.alu, act_b.ctrl,
                             exp_b.pc, exp_b.rs1, exp_b.rs2, exp_b.rd, exp_b.imm, exp_b.f3, exp_b.alu, exp_b.ctrl);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] prog [16] = '{
        32'h40208133, 32'h4050D093, 32'h00209093, 32'h40209093,
        32'hFE209CE3, 32'h000080E7, 32'h000010E7, 32'h00001297,
        32'hFFF10083, 32'h00112023, 32'h00113023, 32'h0000B003,
        32'h02000033, 32'h0000200F, 32'h00002063, 32'h00000002
    };
    logic [15:0] rdy_pat = 16'b1011_0110_1101_1110;
    logic        accepted;

    initial begin
        rst = 1'b0; ifv = 1'b1; pc_in = 32'h0000_1234; instr_in = 32'h00500093;
        ex_rdy = 1'b1; flush = 1'b0;
        repeat (3) step();
        chk("rst_valid", 32'(dut_valid), 32'd0);
        chk("rst_ready", 32'(dut_ready), 32'd1);
        chk("rst_ctrl",  32'(dut_ctrl),  32'd0);
        chk("rst_imm",   dut_imm,        32'd0);
        #2 rst = 1'b1;

        // First instruction after reset: addi x1, x0, 5
        pc_in = 32'h8000_0000; instr_in = 32'h00500093;
        step();
        chk("addi_valid", 32'(dut_valid), 32'd1);
        chk("addi_rd",    32'(dut_rd),    32'd1);
        chk("addi_rs1",   32'(dut_rs1),   32'd0);
        chk("addi_imm",   dut_imm,        32'd5);
        chk("addi_alu",   32'(dut_alu),   32'd0);
        chk("addi_ctrl",  32'(dut_ctrl),  32'h001);
        chk("addi_pc",    dut_pc,         32'h8000_0000);

        // Immediate formats, one per cycle
        pc_in = 32'h8000_0004; instr_in = 32'h0020A423; step();
        chk("sw_imm",  dut_imm,         32'd8);
        chk("sw_rs1",  32'(dut_rs1),    32'd1);
        chk("sw_rs2",  32'(dut_rs2),    32'd2);
        chk("sw_rd",   32'(dut_rd),     32'd0);
        chk("sw_ctrl", 32'(dut_ctrl),   32'h004);
        pc_in = 32'h8000_0008; instr_in = 32'hFE000EE3; step();
        chk("beq_imm",  dut_imm,        32'hFFFF_FFFC);
        chk("beq_ctrl", 32'(dut_ctrl),  32'h008);
        pc_in = 32'h8000_000C; instr_in = 32'h123452B7; step();
        chk("lui_imm",  dut_imm,        32'h1234_5000);
        chk("lui_rd",   32'(dut_rd),    32'd5);
        chk("lui_ctrl", 32'(dut_ctrl),  32'h041);
        pc_in = 32'h8000_0010; instr_in = 32'h008000EF; step();
        chk("jal_imm",  dut_imm,        32'd8);
        chk("jal_rd",   32'(dut_rd),    32'd1);
        chk("jal_ctrl", 32'(dut_ctrl),  32'h011);

        // Back-pressure with a new instruction (addi x2, x0, 10) waiting
        ex_rdy = 1'b0; pc_in = 32'h8000_0014; instr_in = 32'h00A00113;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("stall_ready", 32'(dut_ready), 32'd0);
            chk("stall_imm",   dut_imm,        32'd8);
            chk("stall_pc",    dut_pc,         32'h8000_0010);
        end
        ex_rdy = 1'b1; #1;
        chk("release_ready", 32'(dut_ready), 32'd1);
        step();
        chk("new_valid", 32'(dut_valid), 32'd1);
        chk("new_imm",   dut_imm,        32'd10);
        chk("new_rd",    32'(dut_rd),    32'd2);
        ifv = 1'b0; step();
        chk("drained_valid", 32'(dut_valid), 32'd0);

        // Flush while holding, with a new offer in the same cycle
        ifv = 1'b1; step();
        chk("pre_flush_valid", 32'(dut_valid), 32'd1);
        flush = 1'b1; ex_rdy = 1'b0; instr_in = 32'h123452B7; pc_in = 32'h8000_0018;
        step();
        chk("flush_valid", 32'(dut_valid), 32'd0);
        flush = 1'b0; ifv = 1'b0; step();
        chk("flush_nolui_valid", 32'(dut_valid), 32'd0);
        flush = 1'b1; ex_rdy = 1'b1; step();
        chk("flush_empty_valid", 32'(dut_valid), 32'd0);
        flush = 1'b0;

        // Illegal encodings and a legal lw
        ifv = 1'b1; pc_in = 32'h8000_0020; instr_in = 32'h00000000; step();
        chk("ill0_ctrl",  32'(dut_ctrl),  32'h100);
        chk("ill0_rd",    32'(dut_rd),    32'd0);
        chk("ill0_valid", 32'(dut_valid), 32'd1);
        instr_in = 32'h40001033; step();
        chk("ill1_ctrl",  32'(dut_ctrl),  32'h100);
        chk("ill1_rd",    32'(dut_rd),    32'd0);
        chk("ill1_valid", 32'(dut_valid), 32'd1);
        instr_in = 32'h0000A003; step();
        chk("lw_ctrl", 32'(dut_ctrl), 32'h003);
        chk("lw_rs1",  32'(dut_rs1),  32'd1);

        // Model-checked stream with intermittent execute back-pressure
        for (int i = 0; i < 16; i++) begin
            instr_in = prog[i];
            pc_in    = 32'h0000_1000 + 32'(i * 4);
            ifv      = 1'b1;
            ex_rdy   = rdy_pat[i];
            accepted = 1'b0;
            for (int k = 0; k < 4 && !accepted; k++) begin
                #1;
                accepted = dut_ready;
                step();
                if (!accepted) ex_rdy = 1'b1;
            end
            chk("stream_accept", 32'(accepted), 32'd1);
        end
        ifv = 1'b0; ex_rdy = 1'b1; step();

        // Asynchronous reset while a bundle is held and stalled
        ifv = 1'b1; instr_in = 32'h00A00113; pc_in = 32'h8000_0040; step();
        ifv = 1'b0; ex_rdy = 1'b0; step();
        chk("hold_valid", 32'(dut_valid), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("async_valid", 32'(dut_valid), 32'd0);
        chk("async_pc",    dut_pc,         32'd0);
        chk("async_ctrl",  32'(dut_ctrl),  32'd0);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
